tff_jk_bank: RTL and testbench

Parameterised bank of T flip-flop cores, each wrapped with T-to-JK input conversion so the bank behaves as a W-bit JK register. A second mode chains the T inputs to form a synchronous up/down toggle counter. It sits beside the JK-to-T conversion cells in the flip-flop conversion library. It gives the JK function built on a T core, and adds the toggle-chain counter that T flip-flops are normally used for.

---
 rtl/tff_jk_bank.sv | 121 ++++++++++++
 tb/tb_tff_jk_bank.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/tff_jk_bank.sv
// Bank of W T flip-flops driven through T-to-JK conversion, or chained as an up/down toggle counter.
// Optional build macro TFF_JK_BANK_TOG_EN adds the per-cell toggle-mask register on tog.
module tff_jk_bank #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pre,
  input  logic         clr,
  input  logic         mode,
  input  logic [W-1:0] j,
  input  logic [W-1:0] k,
  input  logic         cnt_en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic [W-1:0] q,
  output logic [W-1:0] qbar,
  output logic         wrap,
  output logic [W-1:0] tog
);

  logic [W-1:0] state_q;
  logic [W-1:0] state_d;
  logic         wrap_q;
  logic         wrap_d;
  logic [W-1:0] jk_t_s;
  logic [W-1:0] cnt_t_s;
  logic [W-1:0] t_s;
  logic         force_s;
  logic         carry_up_s;
  logic         carry_dn_s;

  // Toggle vectors: JK conversion per bit, and the ripple-AND chain for counting.
  always_comb begin
    jk_t_s     = (j & ~state_q) | (k & state_q);
    cnt_t_s    = {W{1'b0}};
    carry_up_s = 1'b1;
    carry_dn_s = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (up) begin
        cnt_t_s[i] = carry_up_s;
      end else begin
        cnt_t_s[i] = carry_dn_s;
      end
      carry_up_s = carry_up_s & state_q[i];
      carry_dn_s = carry_dn_s & ~state_q[i];
    end
  end

  // Select the active toggle vector for the current mode.
  always_comb begin
    case (mode)
      1'b0:    t_s = jk_t_s;
      1'b1:    t_s = cnt_en ? cnt_t_s : {W{1'b0}};
      default: t_s = {W{1'b0}};
    endcase
  end

  // Forcing paths (clr over pre over load) bypass the T core; otherwise q ^ t.
  always_comb begin
    force_s = ~clr | ~pre | load;
    if (!clr) begin
      state_d = {W{1'b0}};
    end else if (!pre) begin
      state_d = {W{1'b1}};
    end else if (load) begin
      state_d = load_data;
    end else begin
      state_d = state_q ^ t_s;
    end
  end

  // Rollover happens only on an unforced enabled count from the terminal value.
  always_comb begin
    if (mode && cnt_en && !force_s) begin
      wrap_d = up ? (&state_q) : ~(|state_q);
    end else begin
      wrap_d = 1'b0;
    end
  end

  // Cell state and rollover pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= {W{1'b0}};
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef TFF_JK_BANK_TOG_EN
  logic [W-1:0] tog_q;
  logic [W-1:0] tog_d;

  // Mask of bits that changed on the latest edge, whatever the cause.
  always_comb begin
    tog_d = state_q ^ state_d;
  end

  // Toggle-mask register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tog_q <= {W{1'b0}};
    end else begin
      tog_q <= tog_d;
    end
  end

  assign tog = tog_q;
`else
  assign tog = {W{1'b0}};
`endif

  assign q    = state_q;
  assign qbar = ~state_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_tff_jk_bank.sv
// Self-checking bench for tff_jk_bank (W=4): directed plan steps plus randomized traffic
// compared against an arithmetic reference model.
module tb_tff_jk_bank;
  localparam int W = 4;
`ifdef TFF_JK_BANK_TOG_EN
  localparam bit TOG_EN = 1'b1;
`else
  localparam bit TOG_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         pre;
  logic         clr;
  logic         mode;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         cnt_en;
  logic         up;
  logic         load;
  logic [W-1:0] load_data;
  logic [W-1:0] q;
  logic [W-1:0] qbar;
  logic         wrap;
  logic [W-1:0] tog;

  logic [W-1:0] m_q;
  logic         m_wrap;
  logic [W-1:0] m_tog;
  int           checks;
  int           errors;

  tff_jk_bank #(.W(W)) dut (
    .clk(clk), .rst(rst), .pre(pre), .clr(clr), .mode(mode),
    .j(j), .k(k), .cnt_en(cnt_en), .up(up), .load(load),
    .load_data(load_data), .q(q), .qbar(qbar), .wrap(wrap), .tog(tog)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".q"}, q, m_q);
    chk({tag, ".qbar"}, qbar, ~m_q);
    chk({tag, ".wrap"}, {{(W-1){1'b0}}, wrap}, {{(W-1){1'b0}}, m_wrap});
    chk({tag, ".tog"}, tog, m_tog);
  endtask

  // One clock edge: predict from the current inputs and model state, then compare.
  task automatic step(input string tag);
    logic [W-1:0] nq;
    logic         nw;
    int           val;
    nq = m_q;
    val = int'(m_q);
    if (!clr) nq = '0;
    else if (!pre) nq = '1;
    else if (load) nq = load_data;
    else if (!mode) begin
      for (int i = 0; i < W; i++) begin
        case ({j[i], k[i]})
          2'b10:   nq[i] = 1'b1;
          2'b01:   nq[i] = 1'b0;
          2'b11:   nq[i] = ~m_q[i];
          default: nq[i] = m_q[i];
        endcase
      end
    end else if (cnt_en) begin
      val = up ? (val + 1) % (1 << W) : (val + (1 << W) - 1) % (1 << W);
      nq = W'(val);
    end
    nw = clr && pre && !load && mode && cnt_en &&
         ((up && int'(m_q) == (1 << W) - 1) || (!up && int'(m_q) == 0));
    @(posedge clk);
    #1;
    m_tog  = TOG_EN ? (m_q ^ nq) : '0;
    m_q    = nq;
    m_wrap = nw;
    chk_all(tag);
  endtask

  task automatic idle_inputs();
    clr = 1'b1; pre = 1'b1; load = 1'b0; load_data = '0;
    mode = 1'b0; j = '0; k = '0; cnt_en = 1'b0; up = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    rst = 1'b1;
    m_q = '0; m_wrap = 1'b0; m_tog = '0;
    #3;
    chk_all("reset");
    #9 rst = 1'b0;

    // JK conversion.
    j = 4'b0011; k = 4'b0101;
    step("jk1");
    chk("jk1.const", q, 4'b0011);
    step("jk2");
    chk("jk2.const", q, 4'b0010);

    // Clear then count up through a full wrap.
    clr = 1'b0; step("clr0"); clr = 1'b1;
    mode = 1'b1; up = 1'b1; cnt_en = 1'b1;
    for (int n = 0; n < 16; n++) step("up16");
    chk("up16.wrap", {3'b000, wrap}, 4'b0001);
    chk("up16.tog", tog, TOG_EN ? 4'hF : 4'h0);
    step("up_after");
    chk("up_after.wrap", {3'b000, wrap}, 4'b0000);

    // Down from zero wraps to all-ones, then hold.
    clr = 1'b0; step("clr1"); clr = 1'b1;
    up = 1'b0;
    step("down_wrap");
    chk("down_wrap.q", q, 4'hF);
    chk("down_wrap.wrap", {3'b000, wrap}, 4'b0001);
    cnt_en = 1'b0;
    for (int n = 0; n < 3; n++) step("hold");
    chk("hold.q", q, 4'hF);

    // Priority: clr over pre over load.
    load = 1'b1; load_data = 4'hA; clr = 1'b0; pre = 1'b0;
    step("prio_clr");
    chk("prio_clr.q", q, 4'h0);
    load = 1'b0; clr = 1'b1;
    step("prio_pre");
    chk("prio_pre.q", q, 4'hF);
    pre = 1'b1; load = 1'b1;
    step("prio_load");
    chk("prio_load.q", q, 4'hA);
    load = 1'b0;

    // Asynchronous reset mid-count.
    clr = 1'b0; step("clr2"); clr = 1'b1;
    up = 1'b1; cnt_en = 1'b1;
    for (int n = 0; n < 7; n++) step("up7");
    chk("up7.q", q, 4'h7);
    rst = 1'b1;
    #1;
    m_q = '0; m_wrap = 1'b0; m_tog = '0;
    chk_all("async_rst");
    chk("async_rst.qbar", qbar, 4'hF);
    rst = 1'b0;
    step("post_rst");
    chk("post_rst.q", q, 4'h1);

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      clr       = ($urandom_range(0, 15) != 0);
      pre       = ($urandom_range(0, 15) != 0);
      load      = ($urandom_range(0, 9) == 0);
      load_data = W'($urandom);
      mode      = ($urandom_range(0, 1) == 1);
      j         = W'($urandom);
      k         = W'($urandom);
      cnt_en    = ($urandom_range(0, 4) != 0);
      up        = ($urandom_range(0, 1) == 1);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
